// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   mem_op_t      : access type driven by the core on instType_i
//   EXC_*         : mcause codes returned on memException_o
//   TX*_OFS       : byte offsets of the console registers inside the MMIO page
package Common;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_t;

  localparam logic [31:0] EXC_NONE           = 32'd0;
  localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] EXC_LOAD_FAULT     = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_STORE_FAULT    = 32'd7;

  localparam logic [31:0] TXDATA_OFS   = 32'd0;
  localparam logic [31:0] TXSTATUS_OFS = 32'd4;

endpackage

// File: rtl/data_mem_responder_tx.sv
// Console TX FIFO.
//   clk, rst (async, active low)
//   push/push_data : enqueue; taken when not full, or when full and popping
//   pop            : dequeue; ignored when empty
//   head           : entry at the read pointer (registered storage, no fall-through)
//   full/empty/count
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees its slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory interface.
//   instType_i/dataAddress_i/writeData_i : access from a single-cycle core
//   readData_o, memException_o           : combinational load data / mcause (0 = ok)
//   tx_data_o/tx_valid_o/tx_ready_i      : console byte stream drained from the TX FIFO
// Backs a word RAM at [0, MEM_WORDS*4) and a two-register MMIO page at
// MMIO_BASE (+0 TXDATA, +4 TXSTATUS). Stores commit on posedge; an access
// that raises an exception has no side effects.
module data_mem_responder
  import Common::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  instType_i,
  input  logic [31:0] dataAddress_i,
  input  logic [31:0] writeData_i,
  output logic [31:0] readData_o,
  output logic [31:0] memException_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int          RAW       = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0] ram_q [MEM_WORDS];

  logic          is_load, is_store, sz_h, sz_w, signed_ld;
  logic          misalign, in_ram, at_txdata, at_txstat;
  logic [RAW-1:0] widx;
  logic [31:0]   rword, status;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic          push, pop;
  logic          ovf_q, ovf_d;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign widx      = dataAddress_i[RAW+1:2];
  assign rword     = ram_q[widx];
  assign rbyte     = rword[{dataAddress_i[1:0], 3'b000} +: 8];
  assign rhalf     = rword[{dataAddress_i[1], 4'b0000} +: 16];
  assign in_ram    = dataAddress_i < RAM_BYTES;
  assign at_txdata = dataAddress_i == (MMIO_BASE + TXDATA_OFS);
  assign at_txstat = dataAddress_i == (MMIO_BASE + TXSTATUS_OFS);
  assign status    = {16'h0, 8'(fifo_count), 5'b0, ovf_q, fifo_empty, fifo_full};
  assign pop       = tx_valid_o & tx_ready_i;

  always_comb begin
    is_load = 1'b0; is_store = 1'b0; sz_h = 1'b0; sz_w = 1'b0; signed_ld = 1'b0;
    case (mem_op_t'(instType_i))
      LB:      begin is_load  = 1'b1; signed_ld = 1'b1;            end
      LH:      begin is_load  = 1'b1; signed_ld = 1'b1; sz_h = 1'b1; end
      LW:      begin is_load  = 1'b1; sz_w = 1'b1;                 end
      LBU:     begin is_load  = 1'b1;                              end
      LHU:     begin is_load  = 1'b1; sz_h = 1'b1;                 end
      SB:      begin is_store = 1'b1;                              end
      SH:      begin is_store = 1'b1; sz_h = 1'b1;                 end
      SW:      begin is_store = 1'b1; sz_w = 1'b1;                 end
      default: ;
    endcase
  end

  assign misalign = (sz_h & dataAddress_i[0]) | (sz_w & (dataAddress_i[1:0] != 2'b00));

  always_comb begin
    memException_o = EXC_NONE;
    readData_o     = '0;
    ram_we         = 1'b0;
    ram_be         = 4'b0000;
    ram_wdata      = writeData_i;
    push           = 1'b0;
    ovf_d          = ovf_q;

    if (is_load || is_store) begin
      // Misalignment outranks the region check.
      if (misalign) begin
        memException_o = is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
      end else if (!(in_ram || (sz_w && (at_txdata || at_txstat)))) begin
        memException_o = is_load ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
      end else if (is_load) begin
        if (in_ram) begin
          if (sz_w)      readData_o = rword;
          else if (sz_h) readData_o = {{16{signed_ld & rhalf[15]}}, rhalf};
          else           readData_o = {{24{signed_ld & rbyte[7]}}, rbyte};
        end else if (at_txstat) begin
          readData_o = status;
        end
      end else begin
        if (in_ram) begin
          ram_we = 1'b1;
          if (sz_w) begin
            ram_be = 4'b1111;
          end else if (sz_h) begin
            ram_be    = 4'b0011 << {dataAddress_i[1], 1'b0};
            ram_wdata = {2{writeData_i[15:0]}};
          end else begin
            ram_be    = 4'b0001 << dataAddress_i[1:0];
            ram_wdata = {4{writeData_i[7:0]}};
          end
        end else if (at_txdata) begin
          push = 1'b1;
          if (fifo_full && !pop) ovf_d = 1'b1;
        end else if (writeData_i[2]) begin
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) ram_q[widx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (writeData_i[7:0]),
    .pop       (pop),
    .head      (tx_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import Common::*;

  localparam int          MEM_WORDS  = 1024;
  localparam int          DEPTH      = 8;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam logic [31:0] RAM_BYTES  = 32'(MEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  instType_i;
  logic [31:0] dataAddress_i, writeData_i;
  logic [31:0] readData_o, memException_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .instType_i(instType_i), .dataAddress_i(dataAddress_i),
    .writeData_i(writeData_i), .readData_o(readData_o), .memException_o(memException_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: byte-addressed RAM, byte queue, sticky overflow bit.
  logic [7:0] mem_m [int];
  logic [7:0] q_m [$];
  bit         ovf_m;

  logic [3:0]  cur_op;
  logic [31:0] cur_a, cur_wd, exp_rd, exp_exc;
  logic        cur_rdy;

  function automatic int op_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
    if (op == 4'd3 || op == 4'd8) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model_status();
    int n = q_m.size();
    return {16'h0, 8'(n), 5'b0, ovf_m, n == 0, n == DEPTH};
  endfunction

  function automatic void model_eval(input logic [3:0] op, input logic [31:0] a,
                                     output logic [31:0] exc, output logic [31:0] rd);
    int sz = op_size(op);
    bit ld = (op >= 4'd1 && op <= 4'd5);
    logic [31:0] v;
    exc = 0; rd = 0;
    if (sz == 0) return;
    if ((a % sz) != 0) exc = ld ? 32'd4 : 32'd6;
    else if (!(a < RAM_BYTES || (sz == 4 && (a == BASE || a == BASE + 4)))) exc = ld ? 32'd5 : 32'd7;
    else if (ld) begin
      if (a < RAM_BYTES) begin
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
        if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end else if (a == BASE + 4) rd = model_status();
    end
  endfunction

  function automatic void model_commit(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] wd, input logic rdy);
    logic [31:0] exc, rd;
    int sz = op_size(op);
    model_eval(op, a, exc, rd);
    if (rdy && q_m.size() > 0) void'(q_m.pop_front());
    if (exc != 0 || !(op >= 4'd6 && op <= 4'd8)) return;
    if (a < RAM_BYTES) begin
      for (int i = 0; i < sz; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
    end else if (a == BASE) begin
      if (q_m.size() < DEPTH) q_m.push_back(wd[7:0]);
      else ovf_m = 1'b1;
    end else if (wd[2]) ovf_m = 1'b0;
  endfunction

  // Drive one access mid-cycle and compute what the model expects to see now.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    instType_i = op; dataAddress_i = a; writeData_i = wd; tx_ready_i = rdy;
    cur_op = op; cur_a = a; cur_wd = wd; cur_rdy = rdy;
    model_eval(op, a, exp_exc, exp_rd);
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    model_commit(cur_op, cur_a, cur_wd, cur_rdy);
  endtask

  task automatic test_reset();
    apply(LW, BASE + 4, 0, 0);
    checks++; if (tx_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid act=%b exp=0", tx_valid_o); end
    checks++; if (readData_o !== 32'h2) begin fails++; $display("FAIL reset_status act=%h exp=00000002", readData_o); end
    @(negedge clk); rst = 1'b1;
    apply(NONE, 32'h10, 32'hFFFF_FFFF, 0);
    checks++; if (readData_o !== 0 || memException_o !== 0) begin
      fails++; $display("FAIL none_op act=%h/%h exp=0/0", readData_o, memException_o); end
    commit();
    apply(4'd12, 32'h13, 0, 0);
    checks++; if (readData_o !== 0 || memException_o !== 0) begin
      fails++; $display("FAIL op12_none act=%h/%h exp=0/0", readData_o, memException_o); end
    commit();
  endtask

  task automatic init_ram();
    for (int w = 0; w < 64; w++) begin
      apply(SW, 32'(w * 4), $urandom, 0);
      checks++; if (memException_o !== 0) begin fails++; $display("FAIL init_sw act=%h exp=0", memException_o); end
      commit();
    end
  endtask

  task automatic test_ram_directed();
    logic [31:0] prev;
    apply(SW, 32'h10, 32'hDEAD_BEEF, 0); commit();
    apply(LB, 32'h13, 0, 0);
    checks++; if (readData_o !== 32'hFFFF_FFDE) begin fails++; $display("FAIL lb_13 act=%h exp=FFFFFFDE", readData_o); end
    apply(LBU, 32'h13, 0, 0);
    checks++; if (readData_o !== 32'h0000_00DE) begin fails++; $display("FAIL lbu_13 act=%h exp=000000DE", readData_o); end
    apply(LH, 32'h10, 0, 0);
    checks++; if (readData_o !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_10 act=%h exp=FFFFBEEF", readData_o); end
    apply(LHU, 32'h12, 0, 0);
    checks++; if (readData_o !== 32'h0000_DEAD) begin fails++; $display("FAIL lhu_12 act=%h exp=0000DEAD", readData_o); end
    apply(SB, 32'h11, 32'h1234_5655, 0); commit();
    apply(LW, 32'h10, 0, 0);
    checks++; if (readData_o !== 32'hDEAD_55EF) begin fails++; $display("FAIL sb_merge act=%h exp=DEAD55EF", readData_o); end
    apply(LW, 32'h12, 0, 0);
    checks++; if (memException_o !== 32'd4 || readData_o !== 0) begin
      fails++; $display("FAIL lw_misalign act=%h/%h exp=4/0", memException_o, readData_o); end
    apply(LW, 32'h20, 0, 0); prev = exp_rd;
    apply(SH, 32'h21, 32'hAAAA_BBBB, 0);
    checks++; if (memException_o !== 32'd6) begin fails++; $display("FAIL sh_misalign act=%h exp=6", memException_o); end
    commit();
    apply(LW, 32'h20, 0, 0);
    checks++; if (readData_o !== prev) begin fails++; $display("FAIL sh_no_write act=%h exp=%h", readData_o, prev); end
    apply(LW, RAM_BYTES, 0, 0);
    checks++; if (memException_o !== 32'd5 || readData_o !== 0) begin
      fails++; $display("FAIL lw_fault act=%h/%h exp=5/0", memException_o, readData_o); end
    apply(SB, BASE, 32'h41, 0);
    checks++; if (memException_o !== 32'd7) begin fails++; $display("FAIL sb_mmio act=%h exp=7", memException_o); end
    commit();
    checks++; #1; if (tx_valid_o !== 1'b0) begin fails++; $display("FAIL sb_mmio_nopush act=%b exp=0", tx_valid_o); end
    apply(LW, BASE, 0, 0);
    checks++; if (memException_o !== 0 || readData_o !== 0) begin
      fails++; $display("FAIL lw_txdata act=%h/%h exp=0/0", memException_o, readData_o); end
  endtask

  task automatic test_fifo_fill();
    for (int i = 0; i < DEPTH; i++) begin
      apply(SW, BASE, 32'h10 + 32'(i), 0); commit();
    end
    apply(LW, BASE + 4, 0, 0);
    checks++; if (readData_o !== 32'h0000_0801) begin fails++; $display("FAIL fill_status act=%h exp=00000801", readData_o); end
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h10) begin
      fails++; $display("FAIL fill_head act=%b/%h exp=1/10", tx_valid_o, tx_data_o); end
    apply(SW, BASE, 32'h99, 0); commit();
    apply(LW, BASE + 4, 0, 0);
    checks++; if (readData_o !== 32'h0000_0805) begin fails++; $display("FAIL ovf_status act=%h exp=00000805", readData_o); end
    apply(SW, BASE + 4, 32'h4, 0); commit();
    apply(LW, BASE + 4, 0, 0);
    checks++; if (readData_o !== 32'h0000_0801) begin fails++; $display("FAIL ovf_clear act=%h exp=00000801", readData_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [12];
    for (int i = 0; i < 8; i++) exp_seq[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 4; i++) exp_seq[8 + i] = 8'h20 + 8'(i);
    for (int k = 0; k < 4; k++) begin
      apply(SW, BASE, 32'h20 + 32'(k), 1);
      checks++; if (tx_data_o !== exp_seq[k]) begin fails++; $display("FAIL b2b_head act=%h exp=%h", tx_data_o, exp_seq[k]); end
      commit();
    end
    apply(LW, BASE + 4, 0, 0);
    checks++; if (readData_o !== 32'h0000_0801) begin fails++; $display("FAIL b2b_count act=%h exp=00000801", readData_o); end
    for (int k = 4; k < 12; k++) begin
      apply(NONE, 0, 0, 1);
      checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== exp_seq[k] || tx_data_o !== q_m[0]) begin
        fails++; $display("FAIL drain act=%b/%h exp=1/%h", tx_valid_o, tx_data_o, exp_seq[k]); end
      commit();
    end
    apply(LW, BASE + 4, 0, 0);
    checks++; if (tx_valid_o !== 1'b0 || readData_o !== 32'h2) begin
      fails++; $display("FAIL drained act=%b/%h exp=0/00000002", tx_valid_o, readData_o); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin apply(SW, BASE, 32'hA0 + 32'(i), 0); commit(); end
    apply(NONE, 0, 0, 0);
    checks++; if (tx_valid_o !== 1'b1) begin fails++; $display("FAIL pre_rst_valid act=%b exp=1", tx_valid_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx_valid_o !== 1'b0) begin fails++; $display("FAIL rst_async_valid act=%b exp=0", tx_valid_o); end
    q_m.delete(); ovf_m = 1'b0;
    @(negedge clk); rst = 1'b1;
    apply(LW, BASE + 4, 0, 0);
    checks++; if (readData_o !== 32'h2) begin fails++; $display("FAIL rst_status act=%h exp=00000002", readData_o); end
    commit();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 255));
        6:       a = BASE;
        7:       a = BASE + 4;
        8:       a = RAM_BYTES + 32'($urandom_range(0, 64));
        default: a = 32'h4000_0000 | 32'($urandom_range(0, 255));
      endcase
      apply(4'($urandom_range(0, 15)), a, $urandom, ($urandom_range(0, 2) == 0));
      checks++; if (readData_o !== exp_rd) begin
        fails++; $display("FAIL rnd_rd op=%0d a=%h act=%h exp=%h", cur_op, a, readData_o, exp_rd); end
      checks++; if (memException_o !== exp_exc) begin
        fails++; $display("FAIL rnd_exc op=%0d a=%h act=%h exp=%h", cur_op, a, memException_o, exp_exc); end
      checks++; if (tx_valid_o !== (q_m.size() != 0)) begin
        fails++; $display("FAIL rnd_valid act=%b exp=%b", tx_valid_o, q_m.size() != 0); end
      if (q_m.size() != 0) begin
        checks++; if (tx_data_o !== q_m[0]) begin fails++; $display("FAIL rnd_head act=%h exp=%h", tx_data_o, q_m[0]); end
      end
      commit();
    end
  endtask

  initial begin
    rst = 1'b0; instType_i = 0; dataAddress_i = 0; writeData_i = 0; tx_ready_i = 0;
    ovf_m = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    init_ram();
    test_ram_directed();
    test_fifo_fill();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
